// File: rtl/pipe_fetch_pkg.sv
// Shared encodings for the instruction-fetch stage: next-PC selects, FSM states, bubble word.
package pipe_fetch_pkg;

    typedef enum logic [1:0] {
        PCSRC_PC4 = 2'b00,
        PCSRC_BPC = 2'b01,
        PCSRC_RPC = 2'b10,
        PCSRC_JPC = 2'b11
    } pcsrc_e;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } fetch_state_e;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pipe_npc_mux.sv
// Next-PC select: 4:1 by pcsource, overridden by a pending redirect target.
// Purely combinational, no backpressure.
module pipe_npc_mux
    import pipe_fetch_pkg::*;
(
    input  logic [1:0]  pcsource,
    input  logic [31:0] pc4,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    input  logic        pend_valid,
    input  logic [31:0] pend_target,
    output logic [31:0] sel_target,
    output logic [31:0] npc
);

    always_comb begin
        sel_target = pc4;
        unique case (pcsrc_e'(pcsource))
            PCSRC_PC4: sel_target = pc4;
            PCSRC_BPC: sel_target = bpc;
            PCSRC_RPC: sel_target = rpc;
            PCSRC_JPC: sel_target = jpc;
        endcase
    end

    // An already-latched redirect always beats whatever ID presents now.
    assign npc = pend_valid ? pend_target : sel_target;

endmodule

// File: rtl/pipe_fetch.sv
// Instruction fetch stage: one outstanding imem request, word hold on ID stall, redirect capture.
// imem_ack to ins is 0 cycles; wpcir=0 parks the captured word in S_HOLD and stops requesting.
module pipe_fetch
    import pipe_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        wpcir,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] ins,
    output logic        fetch_busy
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         pend_valid_q, pend_valid_d;
    logic [31:0]  pend_target_q, pend_target_d;
    logic [31:0]  hold_q, hold_d;
    logic         ack_mask_q, ack_mask_d;

    logic [31:0]  pc_plus4;
    logic [31:0]  sel_target;
    logic [31:0]  npc;
    logic         ack_vld;
    logic         load_pc;

    assign pc_plus4 = pc_q + 32'd4;

    // An ack landing in the first cycle after reset belongs to the abandoned request.
    assign ack_vld = imem_ack && !ack_mask_q;

    pipe_npc_mux u_npc_mux (
        .pcsource    (pcsource),
        .pc4         (pc_plus4),
        .bpc         (bpc),
        .rpc         (rpc),
        .jpc         (jpc),
        .pend_valid  (pend_valid_q),
        .pend_target (pend_target_q),
        .sel_target  (sel_target),
        .npc         (npc)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        hold_d        = hold_q;
        ack_mask_d    = 1'b0;
        load_pc       = 1'b0;

        unique case (state_q)
            S_REQ: begin
                if (ack_vld) begin
                    if (wpcir) begin
                        load_pc = 1'b1;
                    end else begin
                        hold_d  = imem_rdata;
                        state_d = S_HOLD;
                    end
                end else if (wpcir && (pcsrc_e'(pcsource) != PCSRC_PC4) && !pend_valid_q) begin
                    // ID moves on past the branch while we still wait; remember where to go.
                    pend_valid_d  = 1'b1;
                    pend_target_d = sel_target;
                end
            end
            S_HOLD: begin
                if (wpcir) begin
                    load_pc = 1'b1;
                    state_d = S_REQ;
                end
            end
        endcase

        if (load_pc) begin
            pc_d         = npc;
            pend_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'h0;
            hold_q        <= 32'h0;
            ack_mask_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            hold_q        <= hold_d;
            ack_mask_q    <= ack_mask_d;
        end
    end

    always_comb begin
        imem_req   = resetn && (state_q == S_REQ);
        imem_addr  = pc_q;
        pc         = pc_q;
        pc4        = pc_plus4;
        fetch_busy = (state_q == S_REQ) && !ack_vld;
        ins        = NOP;
        unique case (state_q)
            S_REQ:  ins = ack_vld ? imem_rdata : NOP;
            S_HOLD: ins = hold_q;
        endcase
    end

endmodule

// File: tb/tb_pipe_fetch.sv
// Directed bench for pipe_fetch: driver pushes per-cycle expectations, negedge monitor pops and compares.
module tb_pipe_fetch;

    logic        clock;
    logic        resetn;
    logic        wpcir;
    logic [1:0]  pcsource;
    logic [31:0] bpc, rpc, jpc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc, pc4, ins;
    logic        fetch_busy;

    pipe_fetch dut (
        .clock      (clock),
        .resetn     (resetn),
        .wpcir      (wpcir),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .rpc        (rpc),
        .jpc        (jpc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .pc4        (pc4),
        .ins        (ins),
        .fetch_busy (fetch_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        req;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   row_idx = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    // Monitor: outputs are combinational, so every driven cycle presents a result at negedge.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            string tag;
            e   = exp_q.pop_front();
            tag = $sformatf("row%0d", row_idx);
            chk({tag, ".imem_req"},   {31'h0, imem_req},   {31'h0, e.req});
            chk({tag, ".imem_addr"},  imem_addr,           e.pc);
            chk({tag, ".pc"},         pc,                  e.pc);
            chk({tag, ".pc4"},        pc4,                 e.pc + 32'd4);
            chk({tag, ".ins"},        ins,                 e.ins);
            chk({tag, ".fetch_busy"}, {31'h0, fetch_busy}, {31'h0, e.busy});
            row_idx++;
        end
    end

    // Called at posedge+1: drive one cycle of inputs, queue what the DUT must show this cycle.
    task automatic row(input logic w, input logic [1:0] ps, input logic ack, input logic [31:0] rd,
                       input logic ereq, input logic [31:0] epc, input logic [31:0] eins,
                       input logic ebusy);
        exp_t e;
        wpcir      = w;
        pcsource   = ps;
        imem_ack   = ack;
        imem_rdata = rd;
        e.req  = ereq;
        e.pc   = epc;
        e.ins  = eins;
        e.busy = ebusy;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn     = 1'b0;
        wpcir      = 1'b0;
        pcsource   = 2'b00;
        bpc        = 32'h0000_0100;
        rpc        = 32'h0000_0020;
        jpc        = 32'h0000_0400;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;

        #3;
        chk("reset.imem_req", {31'h0, imem_req}, 32'h0);
        chk("reset.pc",       pc,                32'h0);
        chk("reset.pc4",      pc4,               32'h4);

        @(posedge clock);
        #1;
        resetn = 1'b1;

        //    w  ps    ack rdata          req pc             ins            busy
        row(1, 2'b00, 1, 32'hDEAD_BEEF, 1, 32'h0000_0000, 32'h0,         1); // ack after reset ignored
        row(1, 2'b00, 1, 32'h1000_0000, 1, 32'h0000_0000, 32'h1000_0000, 0);
        row(1, 2'b00, 1, 32'h1000_0004, 1, 32'h0000_0004, 32'h1000_0004, 0);
        row(1, 2'b00, 0, 32'h0,         1, 32'h0000_0008, 32'h0,         1); // bubble
        row(0, 2'b00, 1, 32'h1000_0008, 1, 32'h0000_0008, 32'h1000_0008, 0); // capture -> hold
        row(0, 2'b00, 0, 32'h0,         0, 32'h0000_0008, 32'h1000_0008, 0);
        row(0, 2'b01, 1, 32'hFFFF_FFFF, 0, 32'h0000_0008, 32'h1000_0008, 0);
        row(1, 2'b00, 0, 32'h0,         0, 32'h0000_0008, 32'h1000_0008, 0); // release hold
        row(1, 2'b00, 1, 32'h1000_000C, 1, 32'h0000_000C, 32'h1000_000C, 0);
        row(1, 2'b00, 1, 32'h1000_0010, 1, 32'h0000_0010, 32'h1000_0010, 0); // branch fetched
        row(1, 2'b01, 1, 32'h1000_0014, 1, 32'h0000_0014, 32'h1000_0014, 0); // delay slot
        row(1, 2'b00, 1, 32'h1000_0100, 1, 32'h0000_0100, 32'h1000_0100, 0);
        row(1, 2'b10, 1, 32'h1000_0104, 1, 32'h0000_0104, 32'h1000_0104, 0); // jr -> 0x20
        row(1, 2'b11, 0, 32'h0,         1, 32'h0000_0020, 32'h0,         1); // pend 0x400
        row(1, 2'b01, 0, 32'h0,         1, 32'h0000_0020, 32'h0,         1); // pending wins
        row(1, 2'b00, 1, 32'h1000_0020, 1, 32'h0000_0020, 32'h1000_0020, 0);
        row(1, 2'b00, 1, 32'h1000_0400, 1, 32'h0000_0400, 32'h1000_0400, 0);
        row(0, 2'b11, 0, 32'h0,         1, 32'h0000_0404, 32'h0,         1); // stalled: no capture
        row(1, 2'b00, 1, 32'h1000_0404, 1, 32'h0000_0404, 32'h1000_0404, 0);
        rpc = 32'hFFFF_FFFC;
        row(1, 2'b10, 1, 32'h1000_0408, 1, 32'h0000_0408, 32'h1000_0408, 0);
        row(1, 2'b00, 1, 32'h1FFF_FFFC, 1, 32'hFFFF_FFFC, 32'h1FFF_FFFC, 0); // pc4 wraps
        row(1, 2'b00, 1, 32'h1000_0000, 1, 32'h0000_0000, 32'h1000_0000, 0);
        row(1, 2'b11, 0, 32'h0,         1, 32'h0000_0004, 32'h0,         1); // pend 0x400

        imem_ack = 1'b0;
        resetn   = 1'b0;
        #1;
        chk("midreset.imem_req", {31'h0, imem_req}, 32'h0);
        chk("midreset.pc",       pc,                32'h0);
        @(posedge clock);
        #1;
        resetn = 1'b1;

        row(1, 2'b00, 1, 32'hDEAD_BEEF, 1, 32'h0000_0000, 32'h0,         1);
        row(1, 2'b00, 1, 32'h1000_0000, 1, 32'h0000_0000, 32'h1000_0000, 0);
        row(1, 2'b00, 1, 32'h1000_0004, 1, 32'h0000_0004, 32'h1000_0004, 0); // pend was cleared
        row(1, 2'b00, 0, 32'h0,         1, 32'h0000_0008, 32'h0,         1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_fetch.md
PIPE_FETCH -- requirements
Module: pipe_fetch

Interface
REQ-001 SHALL have ports: clock  in  1  pipeline clock, all state updates on rising edge.
REQ-002 SHALL have ports: resetn  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: wpcir  in  1  1 = ID accepts fetch output (advance), 0 = ID stall.
REQ-004 SHALL have ports: pcsource  in  2  next-PC select from ID: 00 pc+4, 01 bpc, 10 rpc, 11 jpc.
REQ-005 SHALL have ports: bpc, rpc, jpc  in  32 each  branch target, jr register target, jump target from ID.
REQ-006 SHALL have ports: imem_req  out  1  instruction-memory request.
REQ-007 SHALL have ports: imem_addr  out  32  fetch address, equal to pc.
REQ-008 SHALL have ports: imem_ack  in  1  one-cycle completion strobe for the outstanding request.
REQ-009 SHALL have ports: imem_rdata  in  32  instruction word, valid only when imem_ack=1.
REQ-010 SHALL have ports: pc  out  32  current fetch PC register.
REQ-011 SHALL have ports: pc4  out  32  pc+4, to IF/ID register.
REQ-012 SHALL have ports: ins  out  32  instruction (or NOP bubble), to IF/ID register.
REQ-013 SHALL have ports: fetch_busy  out  1  1 while in S_REQ without imem_ack.
REQ-014 SHALL have parameter: RESET_PC, default 32'h0000_0000, PC value after reset.

Function
REQ-015 SHALL implement FSM states S_REQ (request outstanding) and S_HOLD (word captured, waiting for wpcir).
REQ-016 In S_REQ: imem_req=1 and imem_addr=pc, both held stable until imem_ack.
REQ-017 In S_REQ with imem_ack=1 and wpcir=1: ins=imem_rdata; pc<=npc; stay in S_REQ (back-to-back fetch, 1 cycle per instruction).
REQ-018 In S_REQ with imem_ack=1 and wpcir=0: capture imem_rdata into hold register; pc unchanged; go to S_HOLD.
REQ-019 In S_REQ with imem_ack=0: ins=32'h0 (NOP bubble); pc unchanged; fetch_busy=1.
REQ-020 In S_HOLD: imem_req=0; ins=hold register; on wpcir=1 then pc<=npc and go to S_REQ, else stay.
REQ-021 pc4 SHALL always equal pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
REQ-022 npc = pending target if pend_valid, else the mux selected by pcsource (00 pc+4, 01 bpc, 10 rpc, 11 jpc).
REQ-023 Delay-slot semantics: the word fetched after a branch/jump SHALL be delivered; the redirect takes effect on the following fetch.
REQ-024 If wpcir=1, pcsource!=00 and no fetch completes this cycle (S_REQ, imem_ack=0), SHALL set pend_valid and latch the selected target.
REQ-025 pend_valid SHALL clear on the cycle pc loads npc.
REQ-026 With wpcir=0, pcsource SHALL be ignored for pending capture, because ID re-presents it.
REQ-027 If pend_valid=1 and a new pcsource!=00 arrives with wpcir=1, the existing pending target SHALL win.
REQ-028 All outputs except pc and the FSM SHALL be combinational from state/registers/inputs; latency from imem_ack to ins is 0 cycles.

Reset
REQ-029 resetn=0 SHALL asynchronously set pc=RESET_PC, state=S_REQ, pend_valid=0, pend target=0, hold=0.
REQ-030 While resetn=0 SHALL drive imem_req=0; after deassertion, imem_req=1 on the first cycle.
REQ-031 Reset mid-request SHALL abandon the outstanding fetch; any imem_ack in the first cycle after reset SHALL be ignored.

Structure
REQ-032 A shared package SHALL hold the pcsource encodings, FSM state encoding, NOP=32'h0 and the RESET_PC default.
REQ-033 One sub-module SHALL be used: pipe_npc_mux (combinational 4:1 next-PC select plus pending override); the FSM and registers stay in pipe_fetch.

Verification
REQ-034 Scenario: reset release, imem_ack every cycle, wpcir=1, pcsource=00 -> imem_addr 0,4,8,...; ins tracks imem_rdata each cycle.
REQ-035 Scenario: ack at 0x8, wpcir=0 for 2 cycles -> state S_HOLD, imem_req=0, ins=held word, pc=0x8; then wpcir=1 -> pc=0xC, imem_req=1.
REQ-036 Scenario: pc=0x10 acked with pcsource=01, bpc=0x100 -> pc=0x14 delivered (delay slot), then next fetch address 0x100.
REQ-037 Scenario: pcsource=11, jpc=0x400, wpcir=1 while fetch of 0x20 unacked -> ins=0 bubble, pend latched; ack 0x20 later -> next pc=0x400 with pcsource=00.
REQ-038 Scenario: pc=0xFFFF_FFFC acked -> pc4=0, next imem_addr=0.
REQ-039 Scenario: assert resetn=0 while a request waits for ack -> pc=RESET_PC, imem_req=0 immediately, pend cleared.
